// File: rtl/grant_pkg.sv
// Shared types and constants for the grant decoder slice: FSM encoding and widths.
package grant_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;
  localparam int CNT_W  = 8;

  // 2'b11 is left unnamed on purpose; the FSM default arm recovers it to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } state_e;

endpackage

// File: rtl/dec2to4.sv
// Combinational code-to-one-hot decoder with enable; all-zero when en is low.
module dec2to4
  import grant_pkg::*;
(
  input  logic              en,
  input  logic [CODE_W-1:0] code,
  output logic [N_REQ-1:0]  onehot
);

  for (genvar i = 0; i < N_REQ; i++) begin : g_bit
    assign onehot[i] = en && (code == CODE_W'(i));
  end

endmodule

// File: rtl/grant_decoder4b.sv
// Registered 2-to-4 grant decoder: accept a code, hold a one-hot grant for HOLD_CYCLES,
// then one dead cycle with grant_done. `define EARLY_RELEASE_EN lets done end a grant early.
module grant_decoder4b
  import grant_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              done,
  output logic [N_REQ-1:0]  grant,
  output logic              busy,
  output logic              grant_done
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] dec_grant;
  logic             rel;

`ifdef EARLY_RELEASE_EN
  assign rel = done;
`else
  logic unused_done;
  assign unused_done = done;
  assign rel         = 1'b0;
`endif

  dec2to4 u_dec (
    .en    (in_valid),
    .code  (in_code),
    .onehot(dec_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      grant      <= '0;
      grant_done <= 1'b0;
    end else begin
      grant_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            grant <= dec_grant;
            cnt   <= HOLD_LD;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Exit is tested at zero before decrementing, so the counter never wraps.
          if (cnt == '0 || rel) begin
            grant      <= '0;
            grant_done <= 1'b1;
            state      <= ST_GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_GAP:  state <= ST_IDLE;
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state == ST_GRANT) || (state == ST_GAP);

endmodule

// File: tb/tb_grant_decoder4b.sv
// Directed bench for grant_decoder4b: three instances (HOLD 4, 8, 1) driven in turn.
module tb_grant_decoder4b;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] in_valid;
  logic [2:0] done;
  logic [1:0] in_code  [3];
  logic [3:0] grant    [3];
  logic [2:0] in_ready;
  logic [2:0] busy;
  logic [2:0] grant_done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  grant_decoder4b #(.HOLD_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_code(in_code[0]), .done(done[0]), .grant(grant[0]), .busy(busy[0]),
    .grant_done(grant_done[0]));

  grant_decoder4b #(.HOLD_CYCLES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_code(in_code[1]), .done(done[1]), .grant(grant[1]), .busy(busy[1]),
    .grant_done(grant_done[1]));

  grant_decoder4b #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_code(in_code[2]), .done(done[2]), .grant(grant[2]), .busy(busy[2]),
    .grant_done(grant_done[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Grant must be one-hot or zero on every instance, every cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++)
      chk($sformatf("onehot%0d", d), 32'($onehot0(grant[d])), 32'd1);
  end

  // Called right after the accepting edge; checks len cycles of stable grant.
  task automatic hold_chk(input int d, input logic [3:0] exp, input int len);
    for (int i = 0; i < len; i++) begin
      chk($sformatf("hold%0d_grant_c%0d", d, i), grant[d], exp);
      chk($sformatf("hold%0d_busy_c%0d", d, i), busy[d], 1'b1);
      chk($sformatf("hold%0d_gdone_c%0d", d, i), grant_done[d], 1'b0);
      if (i < len - 1) tick();
    end
  endtask

  task automatic gap_chk(input int d);
    tick();
    chk($sformatf("gap%0d_grant", d), grant[d], 4'b0000);
    chk($sformatf("gap%0d_gdone", d), grant_done[d], 1'b1);
    chk($sformatf("gap%0d_ready", d), in_ready[d], 1'b0);
    tick();
    chk($sformatf("idle%0d_gdone", d), grant_done[d], 1'b0);
    chk($sformatf("idle%0d_ready", d), in_ready[d], 1'b1);
    chk($sformatf("idle%0d_busy", d), busy[d], 1'b0);
  endtask

  task automatic offer(input int d, input logic [1:0] code);
    in_valid[d] = 1'b1;
    in_code[d]  = code;
    tick();
    in_valid[d] = 1'b0;
  endtask

  initial begin
    rst_n    = '0;
    in_valid = '0;
    done     = '0;
    for (int d = 0; d < 3; d++) in_code[d] = 2'd0;

    // Handshake offered during reset must be ignored.
    in_valid[0] = 1'b1;
    in_code[0]  = 2'd2;
    tick();
    tick();
    chk("rst_grant", grant[0], 4'b0000);
    chk("rst_ready", in_ready[0], 1'b1);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_gdone", grant_done[0], 1'b0);
    in_valid[0] = 1'b0;
    #3 rst_n = '1;
    tick();
    chk("post_rst_ready", in_ready[0], 1'b1);
    chk("post_rst_grant", grant[0], 4'b0000);

    // Basic grant to a, HOLD=4.
    offer(0, 2'd3);
    chk("a_ready_low", in_ready[0], 1'b0);
    hold_chk(0, 4'b1000, 4);
    gap_chk(0);

    // in_valid held, code changed mid-grant: ignored until after GAP.
    in_valid[0] = 1'b1;
    in_code[0]  = 2'd2;
    tick();
    in_code[0]  = 2'd0;
    hold_chk(0, 4'b0100, 4);
    gap_chk(0);
    tick();
    in_valid[0] = 1'b0;
    hold_chk(0, 4'b0001, 4);
    gap_chk(0);

    // done in IDLE is ignored.
    done[1] = 1'b1;
    tick();
    done[1] = 1'b0;
    chk("idle_done_ready", in_ready[1], 1'b1);
    chk("idle_done_gdone", grant_done[1], 1'b0);

    // HOLD=8, code 1, done pulsed in grant cycle 2.
    offer(1, 2'd1);
    chk("er_c1", grant[1], 4'b0010);
    tick();
    chk("er_c2", grant[1], 4'b0010);
    done[1] = 1'b1;
`ifdef EARLY_RELEASE_EN
    tick();
    done[1] = 1'b0;
    chk("er_gap_grant", grant[1], 4'b0000);
    chk("er_gap_gdone", grant_done[1], 1'b1);
    tick();
    chk("er_idle_ready", in_ready[1], 1'b1);
    chk("er_idle_gdone", grant_done[1], 1'b0);
`else
    tick();
    done[1] = 1'b0;
    hold_chk(1, 4'b0010, 6);
    gap_chk(1);
`endif

    // HOLD=1, back-to-back codes 0..3 with valid held high.
    in_valid[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] exp;
      exp = 4'b0001 << k;
      in_code[2] = 2'(k);
      tick();
      chk($sformatf("b2b_grant%0d", k), grant[2], exp);
      chk($sformatf("b2b_ready%0d", k), in_ready[2], 1'b0);
      if (k == 3) in_valid[2] = 1'b0;
      gap_chk(2);
    end
    tick();
    chk("b2b_end_grant", grant[2], 4'b0000);

    // Reset in cycle 2 of a HOLD=4 grant.
    offer(0, 2'd3);
    tick();
    chk("mr_pre", grant[0], 4'b1000);
    #2 rst_n[0] = 1'b0;
    #1;
    chk("mr_grant_async", grant[0], 4'b0000);
    chk("mr_ready", in_ready[0], 1'b1);
    chk("mr_busy", busy[0], 1'b0);
    tick();
    #3 rst_n[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mr_nopulse%0d", i), grant_done[0], 1'b0);
      chk($sformatf("mr_idle%0d", i), in_ready[0], 1'b1);
    end
    offer(0, 2'd1);
    hold_chk(0, 4'b0010, 4);
    gap_chk(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
